// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock synchronous FIFO with registered read data.
// Provides full/empty, programmable almost_full/almost_empty, an occupancy
// count and a synchronous clear. Reset (rst) is asynchronous, active-low.
//
// Optional feature macro: FIFO_ERR_EN
//   defined   -> sticky overflow/underflow error registers are built
//   undefined -> overflow/underflow ports are present but tied to 0
//
// Storage is a plain array with a registered read so it maps onto block RAM.
// The array itself has no reset; clr and rst only touch pointers and flags.

module sync_fifo_param #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  // Threshold constants sized to the counter so all compares are width-matched.
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic              full_q,         full_d;
  logic              empty_q,        empty_d;
  logic              almost_full_q,  almost_full_d;
  logic              almost_empty_q, almost_empty_d;

  logic [WIDTH-1:0]  dout_q;
  logic              dout_valid_q;

  logic              wr_accept;
  logic              rd_accept;

  // --------------------------------------------------------------------------
  // Handshake qualification
  // --------------------------------------------------------------------------
  // A write is refused when full even if a read frees a slot the same cycle
  // (no pass-through), and a read is refused when empty even if a write
  // arrives the same cycle (no bypass). clr suppresses both.
  always_comb begin
    wr_accept = wr_en && !full_q  && !clr;
    rd_accept = rd_en && !empty_q && !clr;
  end

  // --------------------------------------------------------------------------
  // Next-state pointers, count and flags
  // --------------------------------------------------------------------------
  // Flags are derived from the next count so they change on the same edge as
  // the count itself and never disagree with it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  // Write port of the storage array; no reset so it can live in block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Registered read port: dout holds the last word read until the next
  // accepted read; clr leaves it untouched, rst zeroes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else if (rd_accept) begin
      dout_q <= mem_q[rd_ptr_q];
    end
  end

  // dout_valid pulses for exactly the cycle after each accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_accept;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags
  // --------------------------------------------------------------------------
`ifdef FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Errors latch on any attempt against a full/empty FIFO; clr wins over a
  // same-cycle error so a clear always leaves both flags low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock synchronous FIFO with registered read data, full/empty and programmable almost-full/almost-empty flags, occupancy count and synchronous clear. It is the general-purpose buffer for 9-bit-class data paths between producer and consumer blocks in the same clock domain, replacing fixed 8x9 storage with configurable width and depth and proper flow-control flags.

## Interface
- WIDTH, 9, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, 6, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of pointers, count and error flags
- wr_en  input  1  write request
- din  input  WIDTH  write data
- rd_en  input  1  read request
- dout  output  WIDTH  read data, registered
- dout_valid  output  1  one-cycle pulse: dout holds newly read word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- ADDR_W = $clog2(DEPTH); wr_ptr, rd_ptr are ADDR_W bits, wrap DEPTH-1 → 0 by natural overflow.
- Write accepted iff wr_en && !full: mem[wr_ptr] ← din, wr_ptr +1.
- Read accepted iff rd_en && !empty: dout ← mem[rd_ptr], rd_ptr +1, dout_valid ← 1 next cycle.
- Both accepted same cycle: count unchanged, both pointers advance.
- Full + wr_en + rd_en: read accepted, write rejected (no pass-through); count DEPTH-1 afterwards.
- Empty + wr_en + rd_en: write accepted, read rejected (no bypass); count 1 afterwards.
- count: +1 on write-only, −1 on read-only, else hold; never exceeds DEPTH or goes below 0.
- full, empty, almost_full, almost_empty are registered, computed from next-state count; always consistent with count in the same cycle.
- dout holds last read word when no read accepted; never driven to Z.
- clr has priority over wr_en/rd_en: pointers 0, count 0, flags to empty state, dout_valid 0, dout unchanged, storage contents not cleared.
- Reset values: wr_ptr 0, rd_ptr 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, dout 0, dout_valid 0, overflow 0, underflow 0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight write/read in that cycle lost.

## Timing
- Write-to-empty-deassert: word written at edge N; empty low, count 1 after edge N.
- Read latency 1: read accepted at edge N; dout/dout_valid valid after edge N, dout_valid low after N+1 unless next read accepted.
- Back-to-back reads at one per cycle hold dout_valid high continuously.
- Flags and count update on the same edge as the pointer change; no extra pipeline stage.
- Reset release synchronous to design elsewhere; first accepted operation on first rising edge with rst high.

## Configuration
- FIFO_ERR_EN defined: overflow set on any cycle wr_en && full; underflow set on any cycle rd_en && empty (evaluated before clr effect is irrelevant: clr clears and wins); both held until rst or clr.
- FIFO_ERR_EN undefined: overflow and underflow ports present, tied to 0; no error registers synthesised. All other behaviour identical.

## Test plan
- Reset, then write 0x001..0x008 on 8 cycles (DEPTH 8) -> count 8, full 1, almost_full 1 from count 6, empty 0.
- From full, 8 consecutive reads -> dout 0x001..0x008 in order, dout_valid high 8 cycles, one cycle after each read; empty 1 at end.
- Write 12 words interleaved with reads to force pointer wrap -> data order preserved across wrap 7→0, count never exceeds 8.
- Full, wr_en=rd_en=1 with din 0x1FF -> oldest word read, 0x1FF not stored, count 7; empty, wr_en=rd_en=1 -> count 1, dout_valid 0.
- With FIFO_ERR_EN: wr_en at full -> overflow 1 and stays; rd_en at empty -> underflow 1; clr -> both 0, count 0, empty 1, dout unchanged.
- Assert rst low mid-burst with count 5 -> asynchronously count 0, empty 1, dout 0, dout_valid 0 before next edge.
